// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 game-key decoder: scan codes and the
// prefix-tracking FSM state type.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_st_t;

endpackage : kbd_pkg

// File: rtl/kbd_game_keys.sv
// Turns PS/2 scan-code bytes into held arrow levels, a de-repeated space pulse,
// and a timeout error pulse for sequences that stall between bytes.
module kbd_game_keys
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_new,
  input  logic [7:0] din,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic       seqError
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value on which the next increment would reach the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  kbd_st_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             right_q, right_d;
  logic             left_q, left_d;
  logic             held_q, held_d;
  logic             space_q, space_d;
  logic             err_q, err_d;

  // State and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      right_q <= 1'b0;
      left_q  <= 1'b0;
      held_q  <= 1'b0;
      space_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      left_q  <= left_d;
      held_q  <= held_d;
      space_q <= space_d;
      err_q   <= err_d;
    end
  end

  // Byte decode, flag updates and inter-byte timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    left_d  = left_q;
    held_d  = held_q;
    space_d = 1'b0;
    err_d   = 1'b0;

    if (din_new) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (din == SC_EXT) begin
            state_d = ST_EXT;
          end else if (din == SC_BRK) begin
            state_d = ST_BRK;
          end else if (din == SC_SPACE) begin
            space_d = ~held_q;
            held_d  = 1'b1;
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (din == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (din == SC_EXT) begin
            state_d = ST_EXT;
          end else if (din == SC_LEFT) begin
            left_d = 1'b1;
          end else if (din == SC_RIGHT) begin
            right_d = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (din == SC_SPACE) begin
            held_d = 1'b0;
          end else if (din == SC_EXT) begin
            state_d = ST_EXT;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (din == SC_LEFT) begin
            left_d = 1'b0;
          end else if (din == SC_RIGHT) begin
            right_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rightArrow = right_q;
  assign leftArrow  = left_q;
  assign spaceBar   = space_q;
  assign seqError   = err_q;

endmodule : kbd_game_keys

// File: tb/tb_kbd_game_keys.sv
// Directed and randomized checks of kbd_game_keys against a byte-sequence
// reference model that tracks pending prefixes as a queue.
module tb_kbd_game_keys;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_new = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rightArrow, leftArrow, spaceBar, seqError;

  kbd_game_keys #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .din_new   (din_new),
    .din       (din),
    .rightArrow(rightArrow),
    .leftArrow (leftArrow),
    .spaceBar  (spaceBar),
    .seqError  (seqError)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int space_seen = 0;
  int err_seen   = 0;

  // Reference model: bytes of the unfinished sequence, plus key state
  logic [7:0] pend[$];
  bit m_right, m_left, m_held, m_space, m_err;
  int gap;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    pend.delete();
    m_right = 0; m_left = 0; m_held = 0; m_space = 0; m_err = 0; gap = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (pend.size() == 2) pend.delete();
      else begin pend.delete(); pend.push_back(8'hE0); end
    end else if (b == 8'hF0) begin
      if (pend.size() == 0) pend.push_back(8'hF0);
      else if (pend.size() == 1 && pend[0] == 8'hE0) pend.push_back(8'hF0);
      else pend.delete();
    end else begin
      if (pend.size() == 0) begin
        if (b == 8'h29) begin
          m_space = !m_held;
          m_held  = 1;
        end
      end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
        if (b == 8'h29) m_held = 0;
      end else if (pend.size() == 1) begin
        if (b == 8'h6B) m_left = 1;
        if (b == 8'h74) m_right = 1;
      end else begin
        if (b == 8'h6B) m_left = 0;
        if (b == 8'h74) m_right = 0;
      end
      pend.delete();
    end
  endtask

  task automatic model_clk(input bit nw, input logic [7:0] b);
    m_space = 0;
    m_err   = 0;
    if (nw) begin
      gap = 0;
      model_byte(b);
    end else if (pend.size() != 0) begin
      gap++;
      if (gap == int'(T)) begin
        pend.delete();
        gap   = 0;
        m_err = 1;
      end
    end
  endtask

  // One clock with the given input; compare all outputs just after the edge.
  task automatic step(input bit nw, input logic [7:0] b);
    @(negedge clk);
    din_new = nw;
    din     = nw ? b : 8'($urandom);
    @(posedge clk);
    model_clk(nw, b);
    #1;
    chk("rightArrow", rightArrow, m_right);
    chk("leftArrow",  leftArrow,  m_left);
    chk("spaceBar",   spaceBar,   m_space);
    chk("seqError",   seqError,   m_err);
    space_seen += int'(spaceBar);
    err_seen   += int'(seqError);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    din_new = 1'b0;
    #1;
    model_reset();
    chk("rst_right", rightArrow, 1'b0);
    chk("rst_left",  leftArrow,  1'b0);
    chk("rst_space", spaceBar,   1'b0);
    chk("rst_err",   seqError,   1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int s0, e0, burst;
    logic [7:0] pool [7];
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h29; pool[3] = 8'h6B;
    pool[4] = 8'h74; pool[5] = 8'h1C; pool[6] = 8'h00;

    // Reset state
    model_reset();
    #12;
    chk("init_right", rightArrow, 1'b0);
    chk("init_left",  leftArrow,  1'b0);
    chk("init_space", spaceBar,   1'b0);
    chk("init_err",   seqError,   1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Space press then release
    s0 = space_seen;
    step(1, 8'h29); idle(2);
    step(1, 8'hF0); step(1, 8'h29); idle(2);
    chk_int("space_press_pulses", space_seen - s0, 1);

    // Typematic repeat
    s0 = space_seen;
    step(1, 8'h29); idle(1); step(1, 8'h29); idle(1); step(1, 8'h29); idle(1);
    step(1, 8'hF0); step(1, 8'h29); idle(1); step(1, 8'h29); idle(2);
    chk_int("typematic_pulses", space_seen - s0, 2);
    step(1, 8'hF0); step(1, 8'h29); idle(1);

    // Both arrows
    step(1, 8'hE0); step(1, 8'h74); idle(1);
    step(1, 8'hE0); step(1, 8'h6B); idle(1);
    chk("both_right", rightArrow, 1'b1);
    chk("both_left",  leftArrow,  1'b1);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h74); idle(1);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B); idle(1);
    chk("released_left", leftArrow, 1'b0);

    // Timeout, then a byte arriving just before the limit
    e0 = err_seen;
    step(1, 8'hE0); idle(T); idle(1);
    chk_int("timeout_pulses", err_seen - e0, 1);
    step(1, 8'h6B); idle(1);
    chk("stale_6b_left", leftArrow, 1'b0);
    step(1, 8'hE0); idle(T - 1); step(1, 8'h6B); idle(2);
    chk("late_6b_left", leftArrow, 1'b1);
    chk_int("no_timeout_pulses", err_seen - e0, 1);
    step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B); idle(1);

    // Reset mid-sequence
    step(1, 8'hE0); step(1, 8'h74); step(1, 8'hE0);
    do_reset();
    s0 = space_seen;
    step(1, 8'hF0); step(1, 8'h29); idle(2);
    chk_int("post_reset_space", space_seen - s0, 0);

    // Unknown bytes and back-to-back strobes
    step(1, 8'h1C); step(1, 8'hE0); step(1, 8'h1C); step(1, 8'hF0); step(1, 8'h1C);
    idle(1);
    step(1, 8'hE0); step(1, 8'h74); idle(1);
    chk("b2b_right", rightArrow, 1'b1);

    // Randomized traffic with occasional long gaps and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        burst = $urandom_range(T - 3, T + 3);
        idle(burst);
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, 8'h00);
      end else begin
        step(1, ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 6)]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_kbd_game_keys
